me_vector_writer: RTL and testbench
===================================

// Module: me_vector_writer
// PURPOSE
//  Downstream sink for the block-matching search engine's motion-vector output.
//  Buffers one-cycle vector_wr_req/vector_me strobes in a small FIFO.
//  Back-pressures the search FSM via vector_wait_fifo.
//  Writes each vector as one 32-bit word into HPS-visible SDRAM through an Avalon-MM write master.
//  On frame end it drains, then raises done_irq with the vector count for the ARM.
// PARAMETERS
//  VW           28  vector width ({ref_addr[13:0], act_addr[13:0]}, i.e. 2*(MSBI+1))
//  DEPTH        16  FIFO entries (power of 2)
//  AFULL_MARGIN  4  vector_wait_fifo asserts when level >= DEPTH-AFULL_MARGIN
//  CNT_W        16  width of vector index/count
// PORTS
//  clk              in   1      single clock (same as the search FSM clock)
//  reset_n          in   1      asynchronous, active-low reset
//  vector_wr_req    in   1      vector strobe; each high cycle = one vector
//  vector_me        in   VW     vector payload, valid when vector_wr_req=1
//  vector_wait_fifo out  1      almost-full back-pressure to the search engine
//  frame_finish     in   1      one-cycle pulse: last vector of the frame already issued
//  base_addr        in   32     byte base address of the vector table (word aligned)
//  max_vectors      in   CNT_W  table capacity in words
//  avm_address      out  32     Avalon-MM byte address
//  avm_write        out  1      Avalon-MM write request
//  avm_writedata    out  32     {(32-VW)'b0, vector}
//  avm_waitrequest  in   1      Avalon-MM stall
//  done_irq         out  1      level interrupt: frame flushed
//  irq_ack          in   1      one-cycle ack from HPS; clears done_irq
//  vector_count     out  CNT_W  vectors written this frame (valid while done_irq=1)
//  overflow         out  1      sticky: a vector was dropped (FIFO full or table full)
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, state IDLE, all outputs 0, wr_index=0.
//  FIFO push: vector_wr_req=1 and level<DEPTH.
//   - If level==DEPTH, the vector is dropped and overflow is set, even if a pop occurs that cycle.
//   - Simultaneous push+pop leaves level unchanged.
//   - Pointers wrap modulo DEPTH.
//  vector_wait_fifo is registered: next-cycle value = (next_level >= DEPTH-AFULL_MARGIN).
//   Margin absorbs the search FSM's reaction latency.
//  FSM states: IDLE, WRITE, DRAIN, DONE.
//   IDLE->WRITE when FIFO not empty.
//   WRITE->IDLE when FIFO empty after a pop and no finish pending.
//   IDLE/WRITE->DRAIN on frame_finish; a vector pushed in the same cycle belongs to this frame.
//   DRAIN->DONE when FIFO empty and avm_write=0.
//   DONE->IDLE on irq_ack.
//   frame_finish outside IDLE/WRITE is ignored.
//  Write master (WRITE/DRAIN only):
//   - Present FIFO head: avm_write=1, avm_address=base_addr+(wr_index<<2).
//   - Signals hold stable while avm_waitrequest=1.
//   - Accept = avm_write & ~avm_waitrequest: pop head, wr_index+=1.
//   - Next head may be presented the following cycle (at most 1 word/cycle, registered outputs).
//  Table full: when wr_index==max_vectors, the head is popped without a bus write and overflow is set.
//   - wr_index saturates.
//   - max_vectors=0 drops every vector.
//  DONE:
//   - done_irq=1, vector_count=wr_index.
//   - FIFO keeps accepting vectors (next frame) but does not write them.
//   - irq_ack: done_irq=0, wr_index=0, overflow=0.
//   - irq_ack outside DONE is ignored.
//  base_addr and max_vectors are sampled every cycle; software changes them only while IDLE with done_irq=0.
//  Reset mid-burst aborts the outstanding write (avm_write drops asynchronously); buffered vectors are lost.
// TESTING
//  1. 3 strobes (0x0000001,0x0ABCDEF,0xFFFFFFF), base 0x1000, no stall
//     -> writes at 0x1000/4/8 with 0x00000001,0x00ABCDEF,0x0FFFFFFF.
//  2. Same 3 strobes with avm_waitrequest held 5 cycles per write
//     -> address/data stable during stall, no loss, order kept.
//  3. 20 back-to-back strobes, waitrequest=1 throughout
//     -> vector_wait_fifo=1 the cycle after level reaches 12; 4 vectors dropped; overflow=1.
//  4. frame_finish pulsed with the 5th strobe -> 5 writes, then done_irq=1, vector_count=5.
//     irq_ack -> done_irq=0, next write at base_addr.
//  5. max_vectors=2, 4 strobes + frame_finish -> 2 bus writes, overflow=1, vector_count=2.
//  6. reset_n low while avm_write=1 -> avm_write=0 immediately.
//     After release: level=0, vector_wait_fifo=0, done_irq=0.

Source files
------------

// File: rtl/me_vector_writer_if.sv
// rtl/me_vector_writer_if.sv - Avalon-MM write-master bus between vector writer and SDRAM bridge
interface me_vector_writer_if;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;

   modport master (
      output avm_address,
      output avm_write,
      output avm_writedata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_write,
      input  avm_writedata,
      output avm_waitrequest
   );
endinterface

// File: rtl/me_vector_writer.sv
// rtl/me_vector_writer.sv - motion-vector FIFO and Avalon-MM writer with frame-done interrupt
module me_vector_writer #(
   parameter int VW           = 28,
   parameter int DEPTH        = 16,
   parameter int AFULL_MARGIN = 4,
   parameter int CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   vector_wr_req,
   input  logic [VW-1:0]          vector_me,
   output logic                   vector_wait_fifo,
   input  logic                   frame_finish,
   input  logic [31:0]            base_addr,
   input  logic [CNT_W-1:0]       max_vectors,
   me_vector_writer_if.master     avm_bus,
   output logic                   done_irq,
   input  logic                   irq_ack,
   output logic [CNT_W-1:0]       vector_count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE, WRITE, DRAIN, DONE} state_t;

   state_t            state;
   logic              rst_meta;
   logic              rst_n;
   logic [VW-1:0]     mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     level;
   logic [LW-1:0]     level_next;
   logic [CNT_W-1:0]  wr_index;

   logic full;
   logic empty;
   logic push;
   logic active;
   logic accept;
   logic table_full;
   logic skip;
   logic present;
   logic pop;

   // Asserts asynchronously, releases on a clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   always_comb begin
      full       = (level == LW'(DEPTH));
      empty      = (level == '0);
      push       = vector_wr_req && !full;
      active     = (state == WRITE) || (state == DRAIN);
      accept     = avm_bus.avm_write && !avm_bus.avm_waitrequest;
      table_full = (wr_index == max_vectors);
      // The head leaves the FIFO only on bus accept, or unwritten when the table is full.
      skip       = active && !avm_bus.avm_write && !empty && table_full;
      present    = active && !avm_bus.avm_write && !empty && !table_full;
      pop        = accept || skip;
      level_next = level + LW'(push) - LW'(pop);
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= vector_me;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         level                 <= '0;
         wr_index              <= '0;
         vector_wait_fifo      <= 1'b0;
         overflow              <= 1'b0;
         done_irq              <= 1'b0;
         vector_count          <= '0;
         avm_bus.avm_write     <= 1'b0;
         avm_bus.avm_address   <= '0;
         avm_bus.avm_writedata <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         level            <= level_next;
         vector_wait_fifo <= (level_next >= LW'(DEPTH - AFULL_MARGIN));

         if ((vector_wr_req && full) || skip)
            overflow <= 1'b1;
         else if (state == DONE && irq_ack)
            overflow <= 1'b0;

         if (accept) begin
            avm_bus.avm_write <= 1'b0;
            wr_index          <= wr_index + 1'b1;
         end else if (present) begin
            avm_bus.avm_write     <= 1'b1;
            avm_bus.avm_address   <= base_addr + 32'({wr_index, 2'b00});
            avm_bus.avm_writedata <= {{(32-VW){1'b0}}, mem[rd_ptr]};
         end

         case (state)
            IDLE: begin
               if (frame_finish)
                  state <= DRAIN;
               else if (!empty)
                  state <= WRITE;
            end
            WRITE: begin
               if (frame_finish)
                  state <= DRAIN;
               else if (level_next == '0)
                  state <= IDLE;
            end
            DRAIN: begin
               if (empty && !avm_bus.avm_write) begin
                  state        <= DONE;
                  done_irq     <= 1'b1;
                  vector_count <= wr_index;
               end
            end
            DONE: begin
               if (irq_ack) begin
                  state    <= IDLE;
                  done_irq <= 1'b0;
                  wr_index <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_me_vector_writer.sv
// tb/tb_me_vector_writer.sv - directed self-checking bench for me_vector_writer
module tb_me_vector_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        vector_wr_req;
   logic [27:0] vector_me;
   logic        vector_wait_fifo;
   logic        frame_finish;
   logic [31:0] base_addr;
   logic [15:0] max_vectors;
   logic        done_irq;
   logic        irq_ack;
   logic [15:0] vector_count;
   logic        overflow;

   me_vector_writer_if avm_bus ();

   me_vector_writer dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .vector_wr_req    (vector_wr_req),
      .vector_me        (vector_me),
      .vector_wait_fifo (vector_wait_fifo),
      .frame_finish     (frame_finish),
      .base_addr        (base_addr),
      .max_vectors      (max_vectors),
      .avm_bus          (avm_bus),
      .done_irq         (done_irq),
      .irq_ack          (irq_ack),
      .vector_count     (vector_count),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // 0: no stall, 1: stall forever, 2: stall 5 cycles per write
   int stall_mode = 0;
   int stall_cnt  = 0;
   bit mon_en     = 1'b1;
   bit stall_prev = 1'b0;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   logic [31:0] got_addr [$];
   logic [31:0] got_data [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #2;
      case (stall_mode)
         1: avm_bus.avm_waitrequest = 1'b1;
         2: begin
            if (avm_bus.avm_write && stall_cnt < 5) begin
               avm_bus.avm_waitrequest = 1'b1;
               stall_cnt++;
            end else begin
               avm_bus.avm_waitrequest = 1'b0;
               stall_cnt = 0;
            end
         end
         default: avm_bus.avm_waitrequest = 1'b0;
      endcase
   end

   always @(negedge clk) begin
      if (!mon_en || !reset_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_write", avm_bus.avm_write, 1'b1);
            check("hold_addr", avm_bus.avm_address, prev_addr);
            check("hold_data", avm_bus.avm_writedata, prev_data);
         end
         if (avm_bus.avm_write && !avm_bus.avm_waitrequest) begin
            got_addr.push_back(avm_bus.avm_address);
            got_data.push_back(avm_bus.avm_writedata);
         end
         stall_prev = avm_bus.avm_write && avm_bus.avm_waitrequest;
         prev_addr  = avm_bus.avm_address;
         prev_data  = avm_bus.avm_writedata;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [27:0] v, input bit fin);
      vector_wr_req = 1'b1;
      vector_me     = v;
      frame_finish  = fin;
      tick();
      vector_wr_req = 1'b0;
      frame_finish  = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      for (int i = 0; i < 400 && got_data.size() < n; i++)
         tick();
      check("n_writes", 32'(got_data.size()), 32'(n));
   endtask

   task automatic finish_frame(input bit pulse, input int exp_cnt, input bit exp_ovf);
      if (pulse) begin
         frame_finish = 1'b1;
         tick();
         frame_finish = 1'b0;
      end
      for (int i = 0; i < 400 && !done_irq; i++)
         tick();
      check("done_irq_set", done_irq, 1'b1);
      check("vector_count", vector_count, 32'(exp_cnt));
      check("overflow_pre_ack", overflow, exp_ovf);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      check("done_irq_clr", done_irq, 1'b0);
      check("overflow_clr", overflow, 1'b0);
   endtask

   task automatic expect_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
      if (idx < got_data.size()) begin
         check("wr_addr", got_addr[idx], addr);
         check("wr_data", got_data[idx], data);
      end else begin
         check("wr_missing", 32'(got_data.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      vector_wr_req = 1'b0;
      vector_me     = '0;
      frame_finish  = 1'b0;
      base_addr     = 32'h0000_1000;
      max_vectors   = 16'd100;
      irq_ack       = 1'b0;
      avm_bus.avm_waitrequest = 1'b0;
      tick(3);
      check("rst_write", avm_bus.avm_write, 1'b0);
      check("rst_wait", vector_wait_fifo, 1'b0);
      check("rst_irq", done_irq, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_count", 32'(vector_count), 32'h0);
      reset_n = 1'b1;
      tick(5);

      // 1: three vectors, no stall
      got_addr.delete(); got_data.delete();
      send(28'h0000001, 1'b0);
      send(28'h0ABCDEF, 1'b0);
      send(28'hFFFFFFF, 1'b0);
      wait_writes(3);
      expect_write(0, 32'h0000_1000, 32'h0000_0001);
      expect_write(1, 32'h0000_1004, 32'h00AB_CDEF);
      expect_write(2, 32'h0000_1008, 32'h0FFF_FFFF);
      finish_frame(1'b1, 3, 1'b0);

      // 2: same vectors, 5 stall cycles per write
      stall_mode = 2;
      got_addr.delete(); got_data.delete();
      send(28'h0000001, 1'b0);
      send(28'h0ABCDEF, 1'b0);
      send(28'hFFFFFFF, 1'b0);
      wait_writes(3);
      expect_write(0, 32'h0000_1000, 32'h0000_0001);
      expect_write(1, 32'h0000_1004, 32'h00AB_CDEF);
      expect_write(2, 32'h0000_1008, 32'h0FFF_FFFF);
      stall_mode = 0;
      tick(2);
      finish_frame(1'b1, 3, 1'b0);

      // 3: 20 back-to-back vectors against a stalled bus
      stall_mode = 1;
      tick(2);
      got_addr.delete(); got_data.delete();
      for (int i = 0; i < 20; i++) begin
         send(28'(32'h100 + i), 1'b0);
         if (i == 10) check("afull_lvl11", vector_wait_fifo, 1'b0);
         if (i == 11) check("afull_lvl12", vector_wait_fifo, 1'b1);
      end
      check("ovf_fifo_full", overflow, 1'b1);
      stall_mode = 0;
      wait_writes(16);
      for (int i = 0; i < 16; i++)
         expect_write(i, 32'h0000_1000 + 32'(i * 4), 32'h100 + 32'(i));
      tick(4);
      check("afull_drained", vector_wait_fifo, 1'b0);
      finish_frame(1'b1, 16, 1'b1);

      // 4: frame_finish with the 5th vector; next frame restarts at base
      base_addr = 32'h0000_2000;
      got_addr.delete(); got_data.delete();
      for (int i = 0; i < 5; i++)
         send(28'(32'h200 + i), i == 4);
      finish_frame(1'b0, 5, 1'b0);
      check("f4_writes", 32'(got_data.size()), 32'd5);
      expect_write(4, 32'h0000_2010, 32'h0000_0204);
      got_addr.delete(); got_data.delete();
      send(28'h0000777, 1'b0);
      wait_writes(1);
      expect_write(0, 32'h0000_2000, 32'h0000_0777);
      finish_frame(1'b1, 1, 1'b0);

      // 5: table capacity of 2
      base_addr   = 32'h0000_4000;
      max_vectors = 16'd2;
      got_addr.delete(); got_data.delete();
      for (int i = 0; i < 4; i++)
         send(28'(32'h300 + i), i == 3);
      finish_frame(1'b0, 2, 1'b1);
      check("f5_writes", 32'(got_data.size()), 32'd2);
      expect_write(1, 32'h0000_4004, 32'h0000_0301);
      max_vectors = 16'd100;

      // 6: reset while a write is outstanding
      base_addr  = 32'h0000_3000;
      stall_mode = 1;
      mon_en     = 1'b0;
      for (int i = 0; i < 13; i++)
         send(28'(32'h400 + i), 1'b0);
      tick(3);
      check("pre_rst_write", avm_bus.avm_write, 1'b1);
      check("pre_rst_wait", vector_wait_fifo, 1'b1);
      reset_n = 1'b0;
      #1;
      check("async_write_drop", avm_bus.avm_write, 1'b0);
      check("async_wait_drop", vector_wait_fifo, 1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(4);
      stall_mode = 0;
      got_addr.delete(); got_data.delete();
      mon_en = 1'b1;
      tick(10);
      check("post_rst_wait", vector_wait_fifo, 1'b0);
      check("post_rst_irq", done_irq, 1'b0);
      check("post_rst_ovf", overflow, 1'b0);
      check("post_rst_write", avm_bus.avm_write, 1'b0);
      check("post_rst_empty", 32'(got_data.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
